per_master: RTL and testbench
=============================

# per_master

Peripheral-bus initiator for the openMSP430 core. It turns single commands from a local requester (debug unit, DMA, or test logic) into cycles on the 8-bit-address / 16-bit-data peripheral bus that the SFR, watchdog and other peripherals respond to. It supports word and byte reads and writes, plus atomic bit-set and bit-clear commands. Each bit-set or bit-clear is performed as a back-to-back read-modify-write with no other access in between. Its outputs drive the per_* inputs of every peripheral, and it samples the OR-combined per_dout return bus.

## Interface
Parameters: none.

- mclk  input  1  main system clock; all state updates on the rising edge
- reset_n  input  1  reset, asynchronous, active-low
- cmd_req  input  1  command request; held until accepted
- cmd_ack  output  1  command accepted this cycle
- cmd_op  input  2  00 read, 01 write, 10 bit-set, 11 bit-clear
- cmd_addr  input  9  byte address; bit 0 selects the byte lane
- cmd_byte  input  1  1 = byte access, 0 = word access
- cmd_wdata  input  16  write data, or the bit mask for set/clear
- rsp_valid  output  1  one-cycle pulse marking command completion
- rsp_rdata  output  16  read result, valid while rsp_valid is high
- busy  output  1  a command is in progress
- per_addr  output  8  peripheral word address, equal to cmd_addr[8:1]
- per_din  output  16  peripheral write data
- per_en  output  1  peripheral access strobe
- per_wen  output  2  byte write enables; 00 = read
- per_dout  input  16  OR-combined peripheral read data; combinational in the per_en cycle

## Operation
- FSM states: IDLE, RD, WR.
- cmd_ack = cmd_req & (state==IDLE) & reset_n. This is combinational, and the command is latched on the same edge.
- Transitions out of IDLE:
  - cmd_op 00 → RD
  - cmd_op 01 → WR
  - cmd_op 1x → RD, then WR
- RD state:
  - Drives per_en=1, per_wen=00.
  - per_dout is sampled at the end of the cycle into the read register.
  - Next state is IDLE for a read, or WR for set/clear.
- WR state:
  - Drives per_en=1, per_wen per the rules below, then returns to IDLE.
- Byte lane rules:
  - Word access: per_wen=11 on write. cmd_addr[0] is ignored, so the access is word-aligned.
  - Byte access: per_wen=01 when addr[0]=0, 10 when addr[0]=1. per_din={d[7:0],d[7:0]}, i.e. the byte is replicated on both lanes.
  - Byte read: rsp_rdata = selected lane of per_dout, zero-extended; the other byte is 0.
- Set/clear data:
  - Write data is rd|mask for set, rd&~mask for clear, computed on the selected lane(s).
  - For a byte op, the mask is cmd_wdata[7:0] applied to the selected lane.
- rsp_rdata:
  - Read: the sampled value.
  - Set/clear: the original (pre-modify) value.
  - Write: holds its previous value.
- Outside RD/WR, per_en=0, per_wen=00, per_addr=0, per_din=0, so the shared bus stays clean.
- busy = (state != IDLE).

## Timing
- Reset values: cmd_ack, rsp_valid, busy, per_en are 0; per_wen=00; per_addr, per_din, rsp_rdata are 0; state=IDLE.
- Command latency, with cycle 0 as the accept cycle:
  - Read/write: bus access in cycle 1, rsp_valid in cycle 2.
  - Set/clear: RD in cycle 1, WR in cycle 2, rsp_valid in cycle 3.
- rsp_valid is a registered pulse lasting exactly one cycle. The FSM is already in IDLE during that cycle, so a new command can be accepted in the same cycle as rsp_valid.
- Maximum throughput: one read/write every 2 cycles; one set/clear every 3 cycles.
- The RD→WR step of a set/clear is strictly consecutive, so no other bus access can occur in between.
- cmd_req dropped before cmd_ack: nothing happens. Command inputs are don't-care after acceptance.
- Reset asserted mid-command:
  - Bus outputs clear immediately (asynchronously).
  - The command is aborted, with no rsp_valid and no partial write.
  - After reset_n rises, the first edge accepts new commands.

## Test plan
- Word write then read: write 0x1234 to addr 0x010 → cycle 1 shows per_addr=0x08, per_wen=11, per_din=0x1234; read back gives rsp_rdata=0x1234 in cycle 2.
- Byte read, high lane: addr 0x003, cmd_byte=1, per_dout=0xA55A → per_addr=0x01, per_wen=00; rsp_rdata=0x00A5.
- Byte set on low lane: addr 0x000, mask 0x10, per_dout=0x0001 → WR cycle shows per_wen=01, per_din[7:0]=0x11; rsp_rdata=0x0001 in cycle 3.
- Word clear: addr 0x002, mask 0x0011, per_dout=0x0013 → per_din=0x0002 in cycle 2; per_en is high for exactly 2 consecutive cycles.
- Back-to-back commands: cmd_req held high for two reads → the second cmd_ack coincides with the first rsp_valid; per_en is high in cycles 1 and 3 only.
- Reset mid-command: assert reset_n low during the RD cycle of a bit-set → per_en falls at once; no WR occurs and no rsp_valid is produced; after release, busy=0 and the next command completes normally.

Source files
------------

// File: rtl/per_master.sv
// per_master: peripheral-bus initiator turning local commands into per_* read,
// write and atomic read-modify-write (bit-set / bit-clear) cycles.
module per_master (
    input  logic        mclk,
    input  logic        reset_n,
    input  logic        cmd_req,
    output logic        cmd_ack,
    input  logic [1:0]  cmd_op,
    input  logic [8:0]  cmd_addr,
    input  logic        cmd_byte,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        busy,
    output logic [7:0]  per_addr,
    output logic [15:0] per_din,
    output logic        per_en,
    output logic [1:0]  per_wen,
    input  logic [15:0] per_dout
);

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [8:0]  addr_q, addr_d;
    logic        byte_q, byte_d;
    logic [15:0] mask_q, mask_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [15:0] rsp_rdata_q, rsp_rdata_d;
    logic        per_en_q, per_en_d;
    logic [1:0]  per_wen_q, per_wen_d;
    logic [7:0]  per_addr_q, per_addr_d;
    logic [15:0] per_din_q, per_din_d;
    logic [15:0] rd_sel, mod_val;

    function automatic logic [1:0] lane_wen(input logic b, input logic a0);
        return b ? (a0 ? 2'b10 : 2'b01) : 2'b11;
    endfunction

    function automatic logic [15:0] fmt_din(input logic b, input logic [15:0] d);
        return b ? {d[7:0], d[7:0]} : d;
    endfunction

    assign cmd_ack   = cmd_req & (state_q == IDLE) & reset_n;
    assign busy      = (state_q != IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign per_en    = per_en_q;
    assign per_wen   = per_wen_q;
    assign per_addr  = per_addr_q;
    assign per_din   = per_din_q;

    // Byte reads land zero-extended in the low byte; the RMW modifies that byte
    // and fmt_din replicates it onto both lanes.
    assign rd_sel  = byte_q ? {8'h00, addr_q[0] ? per_dout[15:8] : per_dout[7:0]} : per_dout;
    assign mod_val = op_q[0] ? (rd_sel & ~mask_q) : (rd_sel | mask_q);

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        byte_d      = byte_q;
        mask_d      = mask_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        per_en_d    = 1'b0;
        per_wen_d   = 2'b00;
        per_addr_d  = 8'h00;
        per_din_d   = 16'h0000;
        case (state_q)
            IDLE: if (cmd_ack) begin
                op_d       = cmd_op;
                addr_d     = cmd_addr;
                byte_d     = cmd_byte;
                mask_d     = cmd_wdata;
                state_d    = (cmd_op == 2'b01) ? WR : RD;
                per_en_d   = 1'b1;
                per_addr_d = cmd_addr[8:1];
                per_wen_d  = (cmd_op == 2'b01) ? lane_wen(cmd_byte, cmd_addr[0]) : 2'b00;
                per_din_d  = (cmd_op == 2'b01) ? fmt_din(cmd_byte, cmd_wdata) : 16'h0000;
            end
            RD: begin
                rsp_rdata_d = rd_sel;
                if (op_q[1]) begin
                    state_d    = WR;
                    per_en_d   = 1'b1;
                    per_addr_d = addr_q[8:1];
                    per_wen_d  = lane_wen(byte_q, addr_q[0]);
                    per_din_d  = fmt_din(byte_q, mod_val);
                end else begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                end
            end
            WR: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            op_q        <= 2'b00;
            addr_q      <= 9'h000;
            byte_q      <= 1'b0;
            mask_q      <= 16'h0000;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 16'h0000;
            per_en_q    <= 1'b0;
            per_wen_q   <= 2'b00;
            per_addr_q  <= 8'h00;
            per_din_q   <= 16'h0000;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            byte_q      <= byte_d;
            mask_q      <= mask_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            per_en_q    <= per_en_d;
            per_wen_q   <= per_wen_d;
            per_addr_q  <= per_addr_d;
            per_din_q   <= per_din_d;
        end
    end

endmodule

// File: tb/tb_per_master.sv
// tb_per_master: scoreboard bench for per_master with a peripheral memory model.
module tb_per_master;

    logic        mclk = 1'b0, reset_n = 1'b0, cmd_req = 1'b0, cmd_byte = 1'b0;
    logic [1:0]  cmd_op = 2'b00;
    logic [8:0]  cmd_addr = 9'h000;
    logic [15:0] cmd_wdata = 16'h0000;
    logic        cmd_ack, rsp_valid, busy, per_en;
    logic [15:0] rsp_rdata, per_din, per_dout;
    logic [7:0]  per_addr;
    logic [1:0]  per_wen;

    logic [15:0] pmem [256];
    logic [15:0] ref_mem [256];
    logic        pm_init = 1'b0;
    logic [15:0] sb [$];
    logic [15:0] last_rd = 16'h0000;
    logic [15:0] saved;
    int          vecs = 0, errs = 0;

    per_master dut (
        .mclk(mclk), .reset_n(reset_n), .cmd_req(cmd_req), .cmd_ack(cmd_ack),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_byte(cmd_byte), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
        .per_addr(per_addr), .per_din(per_din), .per_en(per_en), .per_wen(per_wen),
        .per_dout(per_dout)
    );

    always #5 mclk = ~mclk;

    assign per_dout = (per_en && per_wen == 2'b00) ? pmem[per_addr] : 16'h0000;

    always @(posedge mclk) begin
        if (!pm_init) begin
            for (int i = 0; i < 256; i++) pmem[i] <= 16'h0000;
        end else if (per_en) begin
            if (per_wen[0]) pmem[per_addr][7:0]  <= per_din[7:0];
            if (per_wen[1]) pmem[per_addr][15:8] <= per_din[15:8];
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vecs++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    always @(negedge mclk) begin
        if (reset_n && rsp_valid) begin
            if (sb.size() == 0) chk("rsp_spurious", 16'(rsp_valid), 16'h0000);
            else chk("rsp_rdata", rsp_rdata, sb.pop_front());
        end
    end

    // Returns #1 after the accept edge, i.e. in cycle 1 of the command.
    task automatic issue(input logic [1:0] op, input logic [8:0] a, input logic b,
                         input logic [15:0] d, input logic hold);
        logic [7:0]  w;
        logic [15:0] old, lane, nv;
        int n;
        n = 0;
        w = a[8:1];
        cmd_req = 1'b1; cmd_op = op; cmd_addr = a; cmd_byte = b; cmd_wdata = d;
        #1;
        while (!cmd_ack && n < 20) begin
            @(posedge mclk); #1; n++;
        end
        if (!cmd_ack) begin
            chk("ack_timeout", 16'(cmd_ack), 16'h0001);
            cmd_req = 1'b0;
            return;
        end
        old  = ref_mem[w];
        lane = b ? {8'h00, a[0] ? old[15:8] : old[7:0]} : old;
        nv   = (op == 2'b01) ? d : (op[0] ? (lane & ~d) : (lane | d));
        if (op != 2'b00) begin
            if (!b) ref_mem[w] = nv;
            else if (a[0]) ref_mem[w][15:8] = nv[7:0];
            else ref_mem[w][7:0] = nv[7:0];
        end
        if (op != 2'b01) last_rd = lane;
        sb.push_back(last_rd);
        @(posedge mclk); #1;
        if (!hold) cmd_req = 1'b0;
    endtask

    task automatic step();
        @(posedge mclk); #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0000;
        repeat (2) @(posedge mclk);
        pm_init = 1'b1;
        step();
        cmd_req = 1'b1;
        #1;
        chk("rst_ack", 16'(cmd_ack), 16'h0000);
        chk("rst_rsp_valid", 16'(rsp_valid), 16'h0000);
        chk("rst_busy", 16'(busy), 16'h0000);
        chk("rst_per_en", 16'(per_en), 16'h0000);
        chk("rst_per_wen", 16'(per_wen), 16'h0000);
        chk("rst_per_addr", 16'(per_addr), 16'h0000);
        chk("rst_per_din", per_din, 16'h0000);
        chk("rst_rdata", rsp_rdata, 16'h0000);
        cmd_req = 1'b0;
        @(negedge mclk); reset_n = 1'b1;
        step();

        issue(2'b01, 9'h010, 1'b0, 16'h1234, 1'b0);
        chk("wr_per_en", 16'(per_en), 16'h0001);
        chk("wr_per_addr", 16'(per_addr), 16'h0008);
        chk("wr_per_wen", 16'(per_wen), 16'h0003);
        chk("wr_per_din", per_din, 16'h1234);
        chk("wr_busy", 16'(busy), 16'h0001);
        step();
        chk("wr_rsp_valid", 16'(rsp_valid), 16'h0001);
        chk("wr_idle_en", 16'(per_en), 16'h0000);
        issue(2'b00, 9'h010, 1'b0, 16'h0000, 1'b0);
        chk("rd_per_wen", 16'(per_wen), 16'h0000);
        chk("rd_per_din", per_din, 16'h0000);
        step();
        chk("rd_rdata", rsp_rdata, 16'h1234);

        issue(2'b01, 9'h002, 1'b0, 16'hA55A, 1'b0);
        step();
        issue(2'b00, 9'h003, 1'b1, 16'h0000, 1'b0);
        chk("brd_per_addr", 16'(per_addr), 16'h0001);
        chk("brd_per_wen", 16'(per_wen), 16'h0000);
        step();
        chk("brd_rdata", rsp_rdata, 16'h00A5);

        issue(2'b01, 9'h000, 1'b0, 16'h0001, 1'b0);
        step();
        issue(2'b10, 9'h000, 1'b1, 16'h0010, 1'b0);
        chk("bset_rd_wen", 16'(per_wen), 16'h0000);
        step();
        chk("bset_wr_en", 16'(per_en), 16'h0001);
        chk("bset_wr_wen", 16'(per_wen), 16'h0001);
        chk("bset_wr_din", per_din, 16'h1111);
        step();
        chk("bset_rsp_valid", 16'(rsp_valid), 16'h0001);
        chk("bset_rdata", rsp_rdata, 16'h0001);

        issue(2'b01, 9'h002, 1'b0, 16'h0013, 1'b0);
        step();
        issue(2'b11, 9'h002, 1'b0, 16'h0011, 1'b0);
        chk("clr_c1_en", 16'(per_en), 16'h0001);
        step();
        chk("clr_c2_en", 16'(per_en), 16'h0001);
        chk("clr_c2_wen", 16'(per_wen), 16'h0003);
        chk("clr_c2_din", per_din, 16'h0002);
        step();
        chk("clr_c3_en", 16'(per_en), 16'h0000);
        chk("clr_rsp_valid", 16'(rsp_valid), 16'h0001);

        issue(2'b00, 9'h010, 1'b0, 16'h0000, 1'b1);
        chk("b2b_c1_en", 16'(per_en), 16'h0001);
        step();
        chk("b2b_c2_ack", 16'(cmd_ack), 16'h0001);
        chk("b2b_c2_valid", 16'(rsp_valid), 16'h0001);
        chk("b2b_c2_en", 16'(per_en), 16'h0000);
        issue(2'b00, 9'h003, 1'b1, 16'h0000, 1'b0);
        chk("b2b_c3_en", 16'(per_en), 16'h0001);
        step();
        chk("b2b_c4_en", 16'(per_en), 16'h0000);

        issue(2'b01, 9'h020, 1'b0, 16'h00F0, 1'b0);
        step();
        saved = ref_mem[8'h10];
        issue(2'b10, 9'h020, 1'b0, 16'h000F, 1'b0);
        chk("abort_rd_en", 16'(per_en), 16'h0001);
        #1 reset_n = 1'b0;
        #1;
        chk("abort_per_en", 16'(per_en), 16'h0000);
        chk("abort_busy", 16'(busy), 16'h0000);
        chk("abort_valid", 16'(rsp_valid), 16'h0000);
        ref_mem[8'h10] = saved;
        sb.delete();
        last_rd = 16'h0000;
        step();
        step();
        reset_n = 1'b1;
        #1;
        chk("post_rst_busy", 16'(busy), 16'h0000);
        chk("post_rst_rdata", rsp_rdata, 16'h0000);
        issue(2'b00, 9'h020, 1'b0, 16'h0000, 1'b0);
        step();
        chk("post_rst_read", rsp_rdata, 16'h00F0);

        for (int i = 0; i < 40; i++)
            issue(2'($urandom_range(0, 3)), 9'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  16'($urandom), 1'b0);
        repeat (4) step();
        chk("sb_empty", 16'(sb.size()), 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
